// File: rtl/i2s_audio_tx.sv
// Free-running I2S (Philips) master transmitter: derives BCK/LRCK from clk,
// latches one stereo sample pair per frame and shifts it out MSB first.
module i2s_audio_tx #(
  parameter int CLK_DIV     = 4,
  parameter int AUDIO_WIDTH = 16,
  parameter int SLOT_BITS   = 32,
  parameter int UNSIGNED_IN = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [AUDIO_WIDTH-1:0] left_in,
  input  logic [AUDIO_WIDTH-1:0] right_in,
  input  logic                   mute,
  output logic                   sample_ack,
  output logic                   i2s_bck,
  output logic                   i2s_lrck,
  output logic                   i2s_data
);

  localparam int POS_W = $clog2(2 * SLOT_BITS);
  localparam int VEC_N = 1 << POS_W;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * SLOT_BITS - 1);
  localparam logic [POS_W-1:0] SLOT_LEN = POS_W'(SLOT_BITS);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [AUDIO_WIDTH-1:0] MSB_FLIP =
    (UNSIGNED_IN != 0) ? (AUDIO_WIDTH'(1) << (AUDIO_WIDTH - 1)) : '0;

  logic [7:0]             div_cnt_reg;
  logic                   bck_reg;
  logic                   lrck_reg;
  logic                   data_reg;
  logic                   cap_reg;
  logic                   ack_reg;
  logic [POS_W-1:0]       pos_reg;
  logic [AUDIO_WIDTH-1:0] hold_l_reg;
  logic [AUDIO_WIDTH-1:0] hold_r_reg;

  logic                   div_wrap;
  logic [POS_W-1:0]       pos_next;
  logic                   lrck_next;
  logic [POS_W-1:0]       slot_next;
  logic [AUDIO_WIDTH-1:0] word_next;
  logic [VEC_N-1:0]       slot_vec;

  always_comb begin
    div_wrap  = (div_cnt_reg == DIV_LAST);
    pos_next  = (pos_reg == POS_LAST) ? '0 : pos_reg + 1'b1;
    lrck_next = (pos_next >= SLOT_LEN);
    slot_next = lrck_next ? pos_next - SLOT_LEN : pos_next;
    word_next = lrck_next ? hold_r_reg : hold_l_reg;
  end

  // Slot offset 0 is the I2S one-bit delay; offsets past the word are padding.
  for (genvar gi = 0; gi < VEC_N; gi++) begin : g_slot
    if (gi >= 1 && gi <= AUDIO_WIDTH) begin : g_word
      assign slot_vec[gi] = word_next[AUDIO_WIDTH - gi];
    end else begin : g_pad
      assign slot_vec[gi] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
      bck_reg     <= 1'b0;
      lrck_reg    <= 1'b1;
      data_reg    <= 1'b0;
      cap_reg     <= 1'b0;
      ack_reg     <= 1'b0;
      pos_reg     <= POS_LAST;
      hold_l_reg  <= '0;
      hold_r_reg  <= '0;
    end else begin
      // The ack trails the capture edge by one clk.
      ack_reg <= cap_reg;
      cap_reg <= 1'b0;
      if (div_wrap) begin
        div_cnt_reg <= '0;
        bck_reg     <= ~bck_reg;
        if (bck_reg) begin
          pos_reg  <= pos_next;
          lrck_reg <= lrck_next;
          data_reg <= slot_vec[slot_next];
          if (pos_next == '0) begin
            cap_reg    <= 1'b1;
            hold_l_reg <= mute ? '0 : (left_in ^ MSB_FLIP);
            hold_r_reg <= mute ? '0 : (right_in ^ MSB_FLIP);
          end
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + 8'd1;
      end
    end
  end

  assign sample_ack = ack_reg;
  assign i2s_bck    = bck_reg;
  assign i2s_lrck   = lrck_reg;
  assign i2s_data   = data_reg;

endmodule
